boot_word_packer: RTL and testbench
===================================

BOOT_WORD_PACKER -- requirements
Module: boot_word_packer

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, giving the width of the word write address.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of output words buffered (power of two, minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port byte_data, input, 8 bits: byte from the upstream SPI flash reader, valid while byte_load is high.
REQ-006 SHALL have port byte_load, input, 1 bit: level strobe from the reader, possibly high for several clk cycles per byte.
REQ-007 SHALL have port src_done, input, 1 bit: level, high once the reader has finished.
REQ-008 SHALL have port wr_data, output, 32 bits: packed word, little-endian (first byte in [7:0]).
REQ-009 SHALL have port wr_addr, output, ADDR_BITS bits: word address of wr_data.
REQ-010 SHALL have port wr_valid, output, 1 bit: wr_data and wr_addr are valid.
REQ-011 SHALL have port wr_ready, input, 1 bit: the sink accepts the word on a cycle where wr_valid and wr_ready are both high.
REQ-012 SHALL have port checksum, output, 8 bits: mod-256 sum of all accepted bytes.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a word was dropped.
REQ-014 SHALL have port done, output, 1 bit: all data, including the flushed partial word, has been written.

Function
REQ-015 SHALL accept one byte per rising edge of byte_load: high this cycle and low the previous cycle, with byte_data sampled on that same cycle.
REQ-016 SHALL keep a 2-bit byte index and place each byte at lane [8*idx+7 : 8*idx], then increment idx with wrap from 3 to 0.
REQ-017 SHALL push the assembled word into the FIFO on the cycle its 4th byte is accepted, and clear the assembly register to 0.
REQ-018 SHALL, if the FIFO is full when a word completes, drop the word, set overflow, and leave the addresses of later words unadvanced.
REQ-019 SHALL drive wr_valid whenever the FIFO is non-empty, with wr_data equal to the head entry (show-ahead); the FIFO pops on the handshake.
REQ-020 SHALL start wr_addr at 0 and increment it by 1 per handshake, wrapping modulo 2^ADDR_BITS without a flag.
REQ-021 SHALL allow a push and a pop in the same cycle when the FIFO is full; the word is not dropped and the count is unchanged.
REQ-022 SHALL add every accepted byte to checksum, including bytes of a word that is later dropped, and SHALL NOT add pad bytes.
REQ-023 SHALL implement an FSM with states COLLECT, FLUSH, DRAIN and DONE.
REQ-024 In COLLECT, SHALL go to FLUSH when src_done is high and idx != 0, and to DRAIN when src_done is high and idx == 0.
REQ-025 SHALL ignore a byte_load edge on the same cycle src_done rises; src_done has priority.
REQ-026 In FLUSH, SHALL fill the remaining lanes with 8'hFF and push the word once the FIFO is not full, stalling otherwise, then go to DRAIN; overflow is never set here.
REQ-027 In DRAIN, SHALL go to DONE when the FIFO is empty.
REQ-028 In DONE, SHALL hold done high, ignore byte_load, and leave the state only on reset.
REQ-029 SHALL keep done low in every other state.
REQ-030 SHALL ignore byte_load edges in FLUSH, DRAIN and DONE.

Reset
REQ-031 While rst is high, SHALL force state = COLLECT, idx = 0, assembly register = 0, FIFO empty, wr_valid = 0, wr_addr = 0, wr_data = 0, checksum = 0, overflow = 0, done = 0, and the byte_load edge-detect register = 0.
REQ-032 SHALL discard any partial word and FIFO contents on a mid-operation reset, and SHALL NOT produce a spurious write after reset is released.

Structure
REQ-033 SHALL take the state enum (state_t), the constant PAD_BYTE = 8'hFF and the default FIFO_DEPTH from shared package boot_pkg.
REQ-034 SHALL instantiate one sub-module, word_fifo: a synchronous FIFO with parameters WIDTH and DEPTH, ports push, pop, full and empty, and show-ahead output; all other logic stays in boot_word_packer.

Verification
REQ-035 With wr_ready = 1, bytes 01 02 03 04 05 06 07 08 then src_done -> writes (0, 04030201) and (1, 08070605); checksum = 24; done high within 3 cycles of the last write.
REQ-036 With byte_load held high for 4 cycles per byte, bytes AA BB CC DD -> exactly one write, (0, DDCCBBAA).
REQ-037 Bytes 11 22 33 then src_done -> FLUSH writes (0, FF332211); checksum = 66; overflow = 0.
REQ-038 With wr_ready = 0, 5 words sent (FIFO_DEPTH = 4) -> overflow = 1; after wr_ready = 1, exactly 4 writes at addresses 0..3 carrying the first 4 words.
REQ-039 Assert rst after 2 bytes of a word, then send 4 new bytes -> a single write at address 0 containing only the new bytes, with checksum covering only the new bytes.
REQ-040 With the FIFO full, a push and a pop on the same cycle -> no drop, overflow stays 0, and all words are written in order.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot image word packer.
package boot_pkg;

    // Packer control states.
    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StFlush   = 2'd1,
        StDrain   = 2'd2,
        StDone    = 2'd3
    } state_t;

    // Filler for unused lanes of the final partial word.
    localparam logic [7:0] PAD_BYTE = 8'hFF;

    // Default number of buffered output words.
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    // Replace every byte lane at or above fill_from with PAD_BYTE.
    function automatic logic [31:0] pad_word(input logic [31:0] word,
                                             input logic [1:0]  fill_from);
        logic [31:0] padded;
        padded = word;
        for (int lane = 0; lane < 4; lane++) begin
            if (lane >= int'(fill_from)) begin
                padded[8*lane +: 8] = PAD_BYTE;
            end
        end
        return padded;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on rdata while not empty.
module word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] PTR_ONE = {{PTR_BITS{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_BITS:0] wr_ptr_q;
    logic [PTR_BITS:0] rd_ptr_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Status flags and handshake qualification; a full FIFO still takes a push
    // when a pop happens in the same cycle.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                  (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        rdata   = mem_q[rd_ptr_q[PTR_BITS-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage; contents are don't-care while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_BITS-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/boot_word_packer.sv
// Packs bytes from the SPI flash reader into little-endian 32-bit words and
// streams them to a word sink with ascending addresses.
module boot_word_packer
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           byte_data,
    input  logic                 byte_load,
    input  logic                 src_done,
    output logic [31:0]          wr_data,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [7:0]           checksum,
    output logic                 overflow,
    output logic                 done
);

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           asm_q, asm_d;
    logic [7:0]            checksum_q, checksum_d;
    logic                  overflow_q, overflow_d;
    logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic                  load_q;

    logic                  load_edge;
    logic [31:0]           merged;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [31:0]           fifo_wdata;
    logic [31:0]           fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;

    word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sink handshake, output drive and the current byte merged into its lane.
    always_comb begin
        load_edge = byte_load & ~load_q;
        fifo_pop  = ~fifo_empty & wr_ready;
        wr_valid  = ~fifo_empty;
        wr_data   = fifo_empty ? 32'h0 : fifo_rdata;
        wr_addr   = wr_addr_q;
        checksum  = checksum_q;
        overflow  = overflow_q;
        done      = (state_q == StDone);
        merged    = asm_q;
        merged[{idx_q, 3'b000} +: 8] = byte_data;
    end

    // Next-state logic: byte collection, word completion, final flush and drain.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        checksum_d = checksum_q;
        overflow_d = overflow_q;
        fifo_push  = 1'b0;
        fifo_wdata = asm_q;

        unique case (state_q)
            StCollect: begin
                // End of source wins over a byte edge in the same cycle.
                if (src_done) begin
                    state_d = (idx_q != 2'd0) ? StFlush : StDrain;
                end else if (load_edge) begin
                    checksum_d = checksum_q + byte_data;
                    idx_d      = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        asm_d = 32'h0;
                        // A simultaneous pop frees the slot, so the word fits.
                        if (!fifo_full || fifo_pop) begin
                            fifo_push  = 1'b1;
                            fifo_wdata = merged;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else begin
                        asm_d = merged;
                    end
                end
            end
            StFlush: begin
                fifo_wdata = pad_word(asm_q, idx_q);
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    asm_d     = 32'h0;
                    idx_d     = 2'd0;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    // Write address advances once per accepted word.
    always_comb begin
        wr_addr_d = wr_addr_q;
        if (fifo_pop) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StCollect;
            idx_q      <= 2'd0;
            asm_q      <= 32'h0;
            checksum_q <= 8'h0;
            overflow_q <= 1'b0;
            wr_addr_q  <= '0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            checksum_q <= checksum_d;
            overflow_q <= overflow_d;
            wr_addr_q  <= wr_addr_d;
            load_q     <= byte_load;
        end
    end

endmodule

// File: tb/tb_boot_word_packer.sv
// Self-checking bench for boot_word_packer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_boot_word_packer;

    localparam int AB    = 4;
    localparam int DEPTH = 4;
    localparam int PH_COLLECT = 0;
    localparam int PH_FLUSH   = 1;
    localparam int PH_DRAIN   = 2;
    localparam int PH_DONE    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    byte_data = 8'h0;
    logic          byte_load = 1'b0;
    logic          src_done = 1'b0;
    logic          wr_ready = 1'b0;
    logic [31:0]   wr_data;
    logic [AB-1:0] wr_addr;
    logic          wr_valid;
    logic [7:0]    checksum;
    logic          overflow;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_ready = 1'b0;
    int ready_pct  = 100;

    // Reference model state.
    logic [31:0]   mq[$];
    logic [7:0]    part[$];
    logic [7:0]    m_sum = 8'h0;
    bit            m_ovf = 1'b0;
    logic [AB-1:0] m_addr = '0;
    bit            m_prev = 1'b0;
    int            m_phase = PH_COLLECT;
    int            m_occ;
    bit            m_pop;
    bit            m_rise;
    logic [31:0]   m_w;
    int            cyc = 0;

    // Sink log.
    logic [31:0]   log_data[$];
    logic [AB-1:0] log_addr[$];
    int            log_cyc[$];
    bit            done_seen = 1'b0;
    int            done_cyc = 0;

    boot_word_packer #(
        .ADDR_BITS  (AB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_data (byte_data),
        .byte_load (byte_load),
        .src_done  (src_done),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .checksum  (checksum),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] log_d(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_a(input int i);
        return (i < log_addr.size()) ? 32'(log_addr[i]) : 32'hDEAD_BEEF;
    endfunction

    // Model: one update per clock edge from the inputs held across that edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            part.delete();
            m_sum   = 8'h0;
            m_ovf   = 1'b0;
            m_addr  = '0;
            m_prev  = 1'b0;
            m_phase = PH_COLLECT;
        end else begin
            m_occ  = mq.size();
            m_pop  = (m_occ > 0) && wr_ready;
            m_rise = byte_load && !m_prev;
            m_prev = byte_load;
            case (m_phase)
                PH_COLLECT: begin
                    if (src_done) begin
                        m_phase = (part.size() != 0) ? PH_FLUSH : PH_DRAIN;
                    end else if (m_rise) begin
                        m_sum = m_sum + byte_data;
                        part.push_back(byte_data);
                        if (part.size() == 4) begin
                            m_w = {part[3], part[2], part[1], part[0]};
                            part.delete();
                            if (m_occ < DEPTH || m_pop) mq.push_back(m_w);
                            else m_ovf = 1'b1;
                        end
                    end
                end
                PH_FLUSH: begin
                    if (m_occ < DEPTH) begin
                        while (part.size() < 4) part.push_back(8'hFF);
                        m_w = {part[3], part[2], part[1], part[0]};
                        part.delete();
                        mq.push_back(m_w);
                        m_phase = PH_DRAIN;
                    end
                end
                PH_DRAIN: begin
                    if (m_occ == 0) m_phase = PH_DONE;
                end
                default: ;
            endcase
            if (m_pop) begin
                void'(mq.pop_front());
                m_addr = m_addr + AB'(1);
            end
        end
    end

    // Compare outputs against the model mid-cycle and log sink writes.
    always @(negedge clk) begin
        if (rst) begin
            log_data.delete();
            log_addr.delete();
            log_cyc.delete();
            done_seen = 1'b0;
            done_cyc  = 0;
        end else begin
            check_eq("wr_valid", 32'(wr_valid), 32'(mq.size() > 0));
            if (wr_valid && mq.size() > 0) begin
                check_eq("wr_data", wr_data, mq[0]);
                check_eq("wr_addr", 32'(wr_addr), 32'(m_addr));
            end
            check_eq("checksum", 32'(checksum), 32'(m_sum));
            check_eq("overflow", 32'(overflow), 32'(m_ovf));
            check_eq("done", 32'(done), 32'(m_phase == PH_DONE));
            if (wr_valid && wr_ready) begin
                log_data.push_back(wr_data);
                log_addr.push_back(wr_addr);
                log_cyc.push_back(cyc);
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rand_ready) wr_ready = ($urandom_range(0, 99) < ready_pct);
        end
    endtask

    task automatic put_byte(input logic [7:0] b, input int hold);
        byte_data = b;
        byte_load = 1'b1;
        tick(hold);
        byte_load = 1'b0;
        byte_data = 8'($urandom);
        tick(1);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        rand_ready = 1'b0;
        byte_load  = 1'b0;
        src_done   = 1'b0;
        byte_data  = 8'h0;
        tick(2);
        @(negedge clk);
        check_eq("rst_wr_valid", 32'(wr_valid), 32'h0);
        check_eq("rst_wr_data", wr_data, 32'h0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'h0);
        check_eq("rst_checksum", 32'(checksum), 32'h0);
        check_eq("rst_overflow", 32'(overflow), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic finish_src(input int bound);
        bit hit;
        hit        = 1'b0;
        rand_ready = 1'b0;
        wr_ready   = 1'b1;
        src_done   = 1'b1;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            if (done) hit = 1'b1;
        end
        check_eq("done_reached", 32'(hit), 32'h1);
        tick(1);
    endtask

    initial begin
        int nb;
        logic [7:0] b [20];

        // Two full words, then end of source.
        do_reset();
        wr_ready = 1'b1;
        for (int i = 1; i <= 8; i++) put_byte(8'(i), 1);
        finish_src(50);
        check_eq("t1_count", 32'(log_data.size()), 32'd2);
        check_eq("t1_addr0", log_a(0), 32'd0);
        check_eq("t1_data0", log_d(0), 32'h0403_0201);
        check_eq("t1_addr1", log_a(1), 32'd1);
        check_eq("t1_data1", log_d(1), 32'h0807_0605);
        check_eq("t1_checksum", 32'(checksum), 32'h24);
        check_eq("t1_done_latency",
                 32'(done_seen && log_cyc.size() == 2 && (done_cyc - log_cyc[1]) <= 3), 32'h1);

        // Long byte_load pulses count once each.
        do_reset();
        wr_ready = 1'b1;
        put_byte(8'hAA, 4);
        put_byte(8'hBB, 4);
        put_byte(8'hCC, 4);
        put_byte(8'hDD, 4);
        finish_src(50);
        check_eq("t2_count", 32'(log_data.size()), 32'd1);
        check_eq("t2_addr0", log_a(0), 32'd0);
        check_eq("t2_data0", log_d(0), 32'hDDCC_BBAA);

        // Partial word flushed with pad bytes.
        do_reset();
        wr_ready = 1'b1;
        put_byte(8'h11, 1);
        put_byte(8'h22, 1);
        put_byte(8'h33, 1);
        finish_src(50);
        check_eq("t3_count", 32'(log_data.size()), 32'd1);
        check_eq("t3_data0", log_d(0), 32'hFF33_2211);
        check_eq("t3_checksum", 32'(checksum), 32'h66);
        check_eq("t3_overflow", 32'(overflow), 32'h0);

        // Five words into a stalled sink: the fifth is dropped.
        do_reset();
        wr_ready = 1'b0;
        for (int i = 1; i <= 20; i++) put_byte(8'(i), 1);
        tick(2);
        @(negedge clk);
        check_eq("t4_overflow", 32'(overflow), 32'h1);
        finish_src(50);
        check_eq("t4_count", 32'(log_data.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq("t4_addr", log_a(k), 32'(k));
            check_eq("t4_data", log_d(k),
                     {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
        end

        // Mid-word reset discards the partial word.
        do_reset();
        wr_ready = 1'b1;
        put_byte(8'h5A, 1);
        put_byte(8'h6B, 1);
        do_reset();
        wr_ready = 1'b1;
        put_byte(8'h10, 1);
        put_byte(8'h20, 1);
        put_byte(8'h30, 1);
        put_byte(8'h40, 1);
        finish_src(50);
        check_eq("t5_count", 32'(log_data.size()), 32'd1);
        check_eq("t5_addr0", log_a(0), 32'd0);
        check_eq("t5_data0", log_d(0), 32'h4030_2010);
        check_eq("t5_checksum", 32'(checksum), 32'hA0);

        // Word completes on the same edge the full FIFO is popped.
        do_reset();
        wr_ready = 1'b0;
        for (int i = 0; i < 20; i++) b[i] = 8'h40 + 8'(i);
        for (int i = 0; i < 19; i++) put_byte(b[i], 1);
        byte_data = b[19];
        byte_load = 1'b1;
        wr_ready  = 1'b1;
        tick(1);
        byte_load = 1'b0;
        tick(1);
        @(negedge clk);
        check_eq("t6_overflow", 32'(overflow), 32'h0);
        finish_src(50);
        check_eq("t6_count", 32'(log_data.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check_eq("t6_addr", log_a(k), 32'(k));
            check_eq("t6_data", log_d(k), {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]});
        end

        // Random traffic with a randomly stalling sink.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            ready_pct  = (r % 3 == 0) ? 10 : ((r % 3 == 1) ? 50 : 90);
            rand_ready = 1'b1;
            nb = $urandom_range(0, 80);
            for (int i = 0; i < nb; i++) begin
                put_byte(8'($urandom), $urandom_range(1, 3));
                tick($urandom_range(0, 2));
                if (r == 4 && i == nb / 2) begin
                    do_reset();
                    rand_ready = 1'b1;
                end
            end
            finish_src(400);
            put_byte(8'h77, 1);
            tick(2);
            check_eq("done_hold", 32'(done), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
